// File: rtl/mem_responder_if.sv
// Byte-wide request port between the CPU memory control unit (master) and the
// memory-side responder (slave).
interface mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  write_enable_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [7:0]            data_i;
  logic [7:0]            data_o;

  modport master (
    output write_enable_i,
    output addr_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  write_enable_i,
    input  addr_i,
    input  data_i,
    output data_o
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: one byte access per cycle from a synchronous RAM, with an
// I/O window holding TX/RX FIFOs, a status register and a sticky halt register.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RAM_AW     = 17,
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_responder_if.slave        bus,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  halt_o
);

  localparam int unsigned TxAw = $clog2(TX_DEPTH);
  localparam int unsigned RxAw = $clog2(RX_DEPTH);

  // Request decode
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic                  is_io;
  logic                  sel_fifo;
  logic                  sel_stat;
  logic                  unused_addr_hi;

  assign addr           = bus.addr_i;
  assign we             = bus.write_enable_i;
  assign is_io          = (addr[17:16] == 2'b11);
  assign sel_fifo       = (addr[17:0] == 18'h30000);
  assign sel_stat       = (addr[17:0] == 18'h30004);
  assign unused_addr_hi = ^addr[ADDR_WIDTH-1:18];

  // RAM: write-on-edge, read sampled into data_q on the same edge
  logic [7:0] ram [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (we && !is_io) ram[addr[RAM_AW-1:0]] <= bus.data_i;
  end

  // TX FIFO
  logic [7:0]  tx_mem [TX_DEPTH];
  logic [TxAw:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic        tx_empty, tx_full, tx_push, tx_drop, tx_pop;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = ((tx_wptr_q ^ tx_rptr_q) == {1'b1, {TxAw{1'b0}}});
  // Fullness is judged at the start of the cycle, so a same-cycle pop cannot rescue a push.
  assign tx_push  = we && sel_fifo && !tx_full;
  assign tx_drop  = we && sel_fifo && tx_full;
  assign tx_pop   = !tx_empty && tx_ready_i;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[TxAw-1:0]] <= bus.data_i;
  end

  assign tx_valid_o = !tx_empty;
  assign tx_data_o  = tx_empty ? 8'h00 : tx_mem[tx_rptr_q[TxAw-1:0]];

  // RX FIFO
  logic [7:0]  rx_mem [RX_DEPTH];
  logic [RxAw:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic        rx_empty, rx_full, rx_push, rx_pop;
  logic        rx_en_q;

  assign rx_empty   = (rx_wptr_q == rx_rptr_q);
  assign rx_full    = ((rx_wptr_q ^ rx_rptr_q) == {1'b1, {RxAw{1'b0}}});
  // rx_en_q keeps rx_ready_o low while in reset and rises on the first edge after release.
  assign rx_ready_o = rx_en_q && !rx_full;
  assign rx_push    = rx_valid_i && rx_ready_o;
  assign rx_pop     = !we && is_io && sel_fifo && !rx_empty;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr_q[RxAw-1:0]] <= rx_data_i;
  end

  // Control / status
  logic [7:0] data_q, data_d;
  logic       ovf_q, ovf_d;
  logic       halt_q, halt_d;

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    halt_d    = halt_q;

    if (tx_push) tx_wptr_d = tx_wptr_q + (TxAw + 1)'(1);
    if (tx_pop)  tx_rptr_d = tx_rptr_q + (TxAw + 1)'(1);
    if (rx_push) rx_wptr_d = rx_wptr_q + (RxAw + 1)'(1);
    if (rx_pop)  rx_rptr_d = rx_rptr_q + (RxAw + 1)'(1);

    // Writes leave data_o holding the last read value.
    if (!we) begin
      if (is_io) begin
        data_d = 8'h00;
        if (sel_fifo && !rx_empty) begin
          data_d = rx_mem[rx_rptr_q[RxAw-1:0]];
        end else if (sel_stat) begin
          data_d = {5'b0, ovf_q, !rx_empty, tx_full};
        end
      end else begin
        data_d = ram[addr[RAM_AW-1:0]];
      end
    end

    // A drop on the same edge as a status read keeps ovf set.
    if (tx_drop) begin
      ovf_d = 1'b1;
    end else if (!we && is_io && sel_stat) begin
      ovf_d = 1'b0;
    end

    if (we && is_io && sel_stat) halt_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      data_q    <= 8'h00;
      ovf_q     <= 1'b0;
      halt_q    <= 1'b0;
      rx_en_q   <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      halt_q    <= halt_d;
      rx_en_q   <= 1'b1;
    end
  end

  assign bus.data_o = data_q;
  assign halt_o     = halt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus a randomized phase, all checked
// against a queue-based reference model of the responder's visible behaviour.
module tb_mem_responder;

  localparam int TxDepth = 8;
  localparam int RxDepth = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       halt;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_WIDTH(32)) bus ();

  mem_responder #(
    .ADDR_WIDTH(32),
    .RAM_AW    (17),
    .TX_DEPTH  (TxDepth),
    .RX_DEPTH  (RxDepth),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .tx_data_o (tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .rx_data_i (rx_data),
    .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready),
    .halt_o    (halt)
  );

  // Reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] m_ram[int];
  logic [7:0] m_data;
  bit         m_ovf;
  bit         m_halt;
  bit         m_rdy;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_data = 8'h00;
    m_ovf  = 1'b0;
    m_halt = 1'b0;
    m_rdy  = 1'b0;
  endtask

  // One request cycle: drive, predict, clock, then check on the falling edge.
  task automatic step(input bit we, input logic [31:0] addr, input logic [7:0] wd,
                      input bit txr, input bit rxv, input logic [7:0] rxd);
    int  tx_n;
    int  rx_n;
    bit  io;
    bit  fifo;
    bit  stat;
    bus.write_enable_i = we;
    bus.addr_i         = addr;
    bus.data_i         = wd;
    tx_ready           = txr;
    rx_valid           = rxv;
    rx_data            = rxd;

    tx_n = tx_q.size();
    rx_n = rx_q.size();
    io   = (addr[17:16] == 2'b11);
    fifo = io && (addr[17:0] == 18'h30000);
    stat = io && (addr[17:0] == 18'h30004);

    if (!we) begin
      if (io) begin
        m_data = 8'h00;
        if (fifo && rx_n > 0) m_data = rx_q.pop_front();
        else if (stat) m_data = {5'b0, m_ovf, rx_n > 0, tx_n == TxDepth};
      end else begin
        m_data = m_ram[int'(addr[16:0])];
      end
    end
    if (we && fifo && tx_n == TxDepth) m_ovf = 1'b1;
    else if (!we && stat) m_ovf = 1'b0;
    if (tx_n > 0 && txr) void'(tx_q.pop_front());
    if (we && fifo && tx_n < TxDepth) tx_q.push_back(wd);
    if (rxv && m_rdy && rx_n < RxDepth) rx_q.push_back(rxd);
    if (we && stat) m_halt = 1'b1;
    if (we && !io) m_ram[int'(addr[16:0])] = wd;

    @(posedge clk);
    m_rdy = 1'b1;
    @(negedge clk);

    chk("data_o", bus.data_o, m_data);
    chk("tx_valid", {7'b0, tx_valid}, {7'b0, tx_q.size() > 0});
    if (tx_q.size() > 0) chk("tx_data", tx_data, tx_q[0]);
    chk("rx_ready", {7'b0, rx_ready}, {7'b0, m_rdy && rx_q.size() < RxDepth});
    chk("halt", {7'b0, halt}, {7'b0, m_halt});
  endtask

  task automatic idle(input bit txr);
    step(1'b0, 32'h0, 8'h00, txr, 1'b0, 8'h00);
  endtask

  task automatic reset_checks();
    chk("rst_data_o", bus.data_o, 8'h00);
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h00);
    chk("rst_halt", {7'b0, halt}, 8'h00);
  endtask

  initial begin
    bus.write_enable_i = 1'b0;
    bus.addr_i         = '0;
    bus.data_i         = '0;
    tx_ready           = 1'b0;
    rx_valid           = 1'b0;
    rx_data            = '0;
    model_reset();
    #1;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;

    // Seed RAM locations that later reads depend on
    step(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b1, 32'h40 + i, 8'($urandom), 1'b0, 1'b0, 8'h00);

    // RAM read-after-write, plus high-address aliasing at the top of RAM
    step(1'b1, 32'h10, 8'hA5, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h10, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b1, 32'h1FFFF, 8'h3C, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'hFFF1FFFF, 8'h00, 1'b0, 1'b0, 8'h00);

    // TX order
    step(1'b1, 32'h30000, 8'h41, 1'b0, 1'b0, 8'h00);
    step(1'b1, 32'h30000, 8'h42, 1'b0, 1'b0, 8'h00);
    step(1'b1, 32'h30000, 8'h43, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // TX overflow and ovf clear-on-read
    for (int i = 0; i < 9; i++) step(1'b1, 32'h30000, 8'(8'h50 + i), 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) idle(1'b1);

    // RX path
    step(1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 8'h7E);
    step(1'b0, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 8'(8'h90 + i));
    for (int i = 0; i < 9; i++) step(1'b0, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00);

    // Other I/O addresses
    step(1'b1, 32'h30008, 8'h77, 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h30008, 8'h00, 1'b0, 1'b0, 8'h00);

    // Streaming push+pop through the TX FIFO
    for (int i = 0; i < 20; i++) step(1'b1, 32'h30000, 8'(8'h60 + i), 1'b1, 1'b0, 8'h00);
    idle(1'b1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int unsigned sel;
      bit          we;
      logic [31:0] a;
      sel = $urandom_range(0, 5);
      we  = 1'($urandom);
      case (sel)
        0:       a = 32'h40 + 32'($urandom_range(0, 15));
        1:       a = 32'h30000;
        2:       begin a = 32'h30004; we = 1'b0; end
        3:       a = 32'h30008;
        4:       begin a = 32'h0; we = 1'b0; end
        default: a = 32'h20040 + 32'($urandom_range(0, 15));
      endcase
      step(we, a, 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    // Drain leftovers so the halt/reset scenario starts clean
    for (int i = 0; i < 9; i++) step(1'b0, 32'h30000, 8'h00, 1'b1, 1'b0, 8'h00);

    // Halt, then reset in the middle of a TX drain
    step(1'b1, 32'h30004, 8'hFF, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h30000, 8'(8'hC0 + i), 1'b0, 1'b0, 8'h00);
    step(1'b0, 32'h40, 8'h00, 1'b1, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
